alu_commit_collector: RTL
=========================

Name: alu_commit_collector

Overview:
- Sits at the receiving end of one ALU commit stream, downstream of the ALU block's per-block response arbiter.
- Accepts partial-width commit beats (NUM_LANES lanes each, tagged pid/sop/eop) and reassembles them per warp into a full NUM_THREADS-wide writeback packet.
- Emits one registered writeback per instruction with its retire count, toward register-file writeback and the commit counters.

Parameters:
- NUM_THREADS, 4, threads per warp; full writeback width in lanes
- NUM_LANES, 2, lanes per input beat; must divide NUM_THREADS
- NUM_WARPS, 4, warps; one reassembly buffer per warp
- XLEN, 32, data and PC width
- NR_BITS, 6, destination register index width
- UUID_WIDTH, 44, instruction uuid width
- Derived: PID_BITS = clog2(NUM_THREADS/NUM_LANES); PID_WIDTH = max(1, PID_BITS); NW_WIDTH = max(1, clog2(NUM_WARPS))

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  commit beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_uuid  in  UUID_WIDTH  instruction uuid
- in_wid  in  NW_WIDTH  warp id
- in_tmask  in  NUM_LANES  lane mask of this beat
- in_PC  in  XLEN  instruction PC
- in_rd  in  NR_BITS  destination register
- in_wb  in  1  register write enable
- in_data  in  NUM_LANES*XLEN  lane results
- in_pid  in  PID_WIDTH  beat index within instruction
- in_sop  in  1  first beat
- in_eop  in  1  last beat
- out_valid  out  1  full writeback valid
- out_ready  in  1  downstream accepts
- out_uuid, out_wid, out_PC, out_rd, out_wb  out  as inputs  fields of completed instruction
- out_tmask  out  NUM_THREADS  assembled thread mask
- out_data  out  NUM_THREADS*XLEN  assembled results
- out_count  out  clog2(NUM_THREADS)+1  popcount(out_tmask), retired threads
- err_proto  out  1  sticky protocol-violation flag

Behaviour:
- Reset: out_valid=0, err_proto=0, every per-warp open flag=0, all per-warp tmask buffers=0. Other outputs are don't-care while out_valid=0. Reset asserted mid-packet discards all partial state; no output is produced for the discarded packets.
- Guarantee provided by upstream: beats of one warp arrive in pid order sop..eop, never interleaved with another instruction of the same warp. Beats of different warps may interleave arbitrarily.
- Per-warp buffer fields: open flag, uuid, PC, rd, wb, tmask[NUM_THREADS], data[NUM_THREADS*XLEN].
- Accepted beat placement: lanes go to thread slots pid*NUM_LANES .. pid*NUM_LANES+NUM_LANES-1. The sop beat clears the whole buffer tmask before merging, and latches uuid/PC/rd/wb. Data of lanes whose in_tmask bit is 0 is still written; out_tmask marks validity.
- in_ready = !out_valid || out_ready. All beats stall while the output register is full and not draining.
- eop beat accepted in cycle N: out_valid=1 in cycle N+1. Output fields come from the buffer merged with that beat; the open flag clears. When PID_BITS=0, sop and eop are both 1 on every beat, and each beat produces one output.
- Output register holds stable while out_valid && !out_ready. out_valid drops the cycle after the handshake unless a new eop beat was accepted in the same cycle, in which case it stays 1 with new contents (full throughput).
- out_count is registered with the output: popcount of the final out_tmask. An all-zero mask gives 0 and still produces an output.
- Protocol errors, each setting err_proto sticky until reset:
  - non-sop beat arriving for a warp with open=0: beat is dropped, no output.
  - sop arriving for a warp with open=1: old contents discarded, new packet started.
- Beats for different warps never corrupt each other's buffers.

Test Plan:
- NUM_THREADS=4, NUM_LANES=2, warp 1: beat pid0 sop tmask=11 data={A,B}, then pid1 eop tmask=01 data={C,X} -> one cycle later out_tmask=0111, out_data lanes0..2={A,B,C}, out_count=3, rd and PC from sop beat.
- Interleaved warps: w0 sop, w2 sop, w2 eop, w0 eop -> outputs in order w2 then w0, each with its own data; no cross-contamination; err_proto=0.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, outputs held stable. When out_ready rises in the same cycle as an accepted eop -> out_valid stays 1 and the next packet appears the following cycle.
- Protocol error: eop beat for warp 3 with no open packet -> no output, err_proto=1 persists. Then a sop for an open warp -> old packet discarded, err_proto remains 1.
- Reset mid-packet: w0 sop accepted, reset pulsed, then w0 pid1 eop -> dropped, err_proto=1. A subsequent full packet completes normally.
- PID_BITS=0 config (NUM_LANES=NUM_THREADS=4): back-to-back sop+eop beats with out_ready=1 -> one output per cycle at latency 1, out_count matches each tmask.

Source files
------------

// File: rtl/alu_commit_collector.sv
// Reassembles partial-width ALU commit beats into one full-warp writeback per
// instruction, with one reassembly buffer per warp and a single output register.
module alu_commit_collector #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int NUM_WARPS   = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int UUID_WIDTH  = 44,
  localparam int PID_BITS   = $clog2(NUM_THREADS / NUM_LANES),
  localparam int PID_WIDTH  = (PID_BITS > 0) ? PID_BITS : 1,
  localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int CNT_WIDTH  = $clog2(NUM_THREADS) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [XLEN-1:0]             in_PC,
  input  logic [NR_BITS-1:0]          in_rd,
  input  logic                        in_wb,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [XLEN-1:0]             out_PC,
  output logic [NR_BITS-1:0]          out_rd,
  output logic                        out_wb,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic                        err_proto
);

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_THREADS-1:0] m);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      c = c + CNT_WIDTH'(m[i]);
    end
    return c;
  endfunction

  logic [NUM_WARPS-1:0]        open_r;
  logic [UUID_WIDTH-1:0]       uuid_r  [NUM_WARPS];
  logic [XLEN-1:0]             pc_r    [NUM_WARPS];
  logic [NR_BITS-1:0]          rd_r    [NUM_WARPS];
  logic                        wb_r    [NUM_WARPS];
  logic [NUM_THREADS-1:0]      tmask_r [NUM_WARPS];
  logic [NUM_THREADS*XLEN-1:0] data_r  [NUM_WARPS];

  logic                        out_valid_r;
  logic                        err_r;
  logic [UUID_WIDTH-1:0]       out_uuid_r;
  logic [NW_WIDTH-1:0]         out_wid_r;
  logic [XLEN-1:0]             out_pc_r;
  logic [NR_BITS-1:0]          out_rd_r;
  logic                        out_wb_r;
  logic [NUM_THREADS-1:0]      out_tmask_r;
  logic [NUM_THREADS*XLEN-1:0] out_data_r;
  logic [CNT_WIDTH-1:0]        out_count_r;

  logic                        in_ready_s;
  logic                        fire_s;
  logic                        drop_s;
  logic                        restart_s;
  logic                        load_s;
  logic [PID_WIDTH-1:0]        slot_s;
  logic [UUID_WIDTH-1:0]       m_uuid_s;
  logic [XLEN-1:0]             m_pc_s;
  logic [NR_BITS-1:0]          m_rd_s;
  logic                        m_wb_s;
  logic [NUM_THREADS-1:0]      base_tmask_s;
  logic [NUM_THREADS-1:0]      m_tmask_s;
  logic [NUM_THREADS*XLEN-1:0] m_data_s;

  assign in_ready_s = !out_valid_r || out_ready;
  assign fire_s     = in_valid && in_ready_s;
  assign drop_s     = !in_sop && !open_r[in_wid];
  assign restart_s  = in_sop && open_r[in_wid];
  assign load_s     = fire_s && in_eop && !drop_s;
  // With a single beat per instruction the pid carries no slot information.
  assign slot_s     = (PID_BITS == 0) ? '0 : in_pid;

  // Merge the incoming beat into the addressed warp's buffer contents.
  always_comb begin
    m_uuid_s     = in_sop ? in_uuid : uuid_r[in_wid];
    m_pc_s       = in_sop ? in_PC   : pc_r[in_wid];
    m_rd_s       = in_sop ? in_rd   : rd_r[in_wid];
    m_wb_s       = in_sop ? in_wb   : wb_r[in_wid];
    base_tmask_s = in_sop ? '0      : tmask_r[in_wid];
    m_tmask_s    = base_tmask_s;
    m_data_s     = data_r[in_wid];
    for (int t = 0; t < NUM_THREADS; t++) begin
      m_tmask_s[t] = (PID_WIDTH'(t / NUM_LANES) == slot_s) ? in_tmask[t % NUM_LANES]
                                                            : base_tmask_s[t];
      m_data_s[t*XLEN +: XLEN] = (PID_WIDTH'(t / NUM_LANES) == slot_s)
                                 ? in_data[(t % NUM_LANES)*XLEN +: XLEN]
                                 : data_r[in_wid][t*XLEN +: XLEN];
    end
  end

  // Control state: open flags, masks, sticky error and output valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      open_r      <= '0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        tmask_r[w] <= '0;
      end
    end else begin
      if (fire_s && !drop_s) begin
        tmask_r[in_wid] <= m_tmask_s;
        open_r[in_wid]  <= !in_eop;
      end
      if (fire_s && (drop_s || restart_s)) begin
        err_r <= 1'b1;
      end
      if (load_s) begin
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Payload storage for buffers and output register; qualified by valid/open.
  always_ff @(posedge clk) begin
    if (fire_s && !drop_s) begin
      uuid_r[in_wid] <= m_uuid_s;
      pc_r[in_wid]   <= m_pc_s;
      rd_r[in_wid]   <= m_rd_s;
      wb_r[in_wid]   <= m_wb_s;
      data_r[in_wid] <= m_data_s;
    end
    if (load_s) begin
      out_uuid_r  <= m_uuid_s;
      out_wid_r   <= in_wid;
      out_pc_r    <= m_pc_s;
      out_rd_r    <= m_rd_s;
      out_wb_r    <= m_wb_s;
      out_tmask_r <= m_tmask_s;
      out_data_r  <= m_data_s;
      out_count_r <= popcount(m_tmask_s);
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_uuid  = out_uuid_r;
  assign out_wid   = out_wid_r;
  assign out_PC    = out_pc_r;
  assign out_rd    = out_rd_r;
  assign out_wb    = out_wb_r;
  assign out_tmask = out_tmask_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;
  assign err_proto = err_r;

endmodule
